// File: rtl/fifo_pkg.sv
// Shared FIFO types and pointer encoding helpers for the FIFO controller
// and the register block.
package fifo_pkg;

  localparam int unsigned PTR_MAX_W = 13;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
    logic ovrflw;
    logic undrflw;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RST = '{
    full:    1'b0,
    empty:   1'b1,
    afull:   1'b0,
    aempty:  1'b1,
    ovrflw:  1'b0,
    undrflw: 1'b0
  };

  function automatic ptr_max_t bin2gry(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down recovers the binary value.
  function automatic ptr_max_t gry2bin(input ptr_max_t g);
    ptr_max_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = int'(PTR_MAX_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Request and status bundle between FIFO clients and fifo_ptr_ctrl.
interface fifo_ptr_ctrl_if #(
  parameter int unsigned DEPTH_W = 4
);
  logic               flush;
  logic               wr_en;
  logic               rd_en;
  logic               clr_err;
  logic [DEPTH_W-1:0] wr_addr;
  logic [DEPTH_W-1:0] rd_addr;
  logic               ram_wr;
  logic               ram_rd;
  logic [DEPTH_W:0]   wr_ptr_gry;
  logic [DEPTH_W:0]   rd_ptr_gry;
  logic [DEPTH_W:0]   occ;
  logic               full;
  logic               empty;
  logic               afull;
  logic               aempty;
  logic               ovrflw;
  logic               undrflw;

  modport master (
    output flush, wr_en, rd_en, clr_err,
    input  wr_addr, rd_addr, ram_wr, ram_rd, wr_ptr_gry, rd_ptr_gry, occ,
    input  full, empty, afull, aempty, ovrflw, undrflw
  );

  modport slave (
    input  flush, wr_en, rd_en, clr_err,
    output wr_addr, rd_addr, ram_wr, ram_rd, wr_ptr_gry, rd_ptr_gry, occ,
    output full, empty, afull, aempty, ovrflw, undrflw
  );
endinterface

// File: rtl/fifo_ptr.sv
// One FIFO pointer: binary counter with wrap bit plus a registered Gray copy
// that updates on the same edge.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] bin_ptr,
  output logic [W-1:0] gry_ptr
);

  logic [W-1:0] r_bin;
  logic [W-1:0] r_gry;
  logic [W-1:0] w_nxt;

  always_comb begin
    w_nxt = clr ? '0 : r_bin + W'(inc);
  end

  // Gray is encoded from the next binary value so both registers move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin <= '0;
      r_gry <= '0;
    end else begin
      r_bin <= w_nxt;
      r_gry <= W'(bin2gry(PTR_MAX_W'(w_nxt)));
    end
  end

  assign bin_ptr = r_bin;
  assign gry_ptr = r_gry;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Single-clock FIFO pointer/flag controller: RAM addresses and strobes,
// Gray pointers, occupancy, status flags and sticky error bits.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH_W    = 4,
  parameter int unsigned AFULL_LVL  = (2 ** DEPTH_W) - 2,
  parameter int unsigned AEMPTY_LVL = 2
) (
  input  logic           clk,
  input  logic           rst,
  fifo_ptr_ctrl_if.slave bus
);

  localparam int unsigned PTR_W = DEPTH_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_V  = PTR_W'(2 ** DEPTH_W);
  localparam logic [PTR_W-1:0] AFULL_V  = PTR_W'(AFULL_LVL);
  localparam logic [PTR_W-1:0] AEMPTY_V = PTR_W'(AEMPTY_LVL);

  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic [PTR_W-1:0] w_wr_gry;
  logic [PTR_W-1:0] w_rd_gry;
  logic [PTR_W-1:0] w_wr_nxt;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [PTR_W-1:0] w_occ_nxt;
  logic [PTR_W-1:0] r_occ;
  logic             w_wa;
  logic             w_ra;
  logic             w_ovf_set;
  logic             w_unf_set;
  fifo_status_t     w_status_nxt;
  fifo_status_t     r_status;

  // Accepts use the registered flags; flush suppresses both.
  always_comb begin
    w_wa      = bus.wr_en & ~r_status.full  & ~bus.flush;
    w_ra      = bus.rd_en & ~r_status.empty & ~bus.flush;
    w_ovf_set = bus.wr_en & r_status.full;
    w_unf_set = bus.rd_en & r_status.empty;
    w_wr_nxt  = bus.flush ? '0 : w_wr_ptr + PTR_W'(w_wa);
    w_rd_nxt  = bus.flush ? '0 : w_rd_ptr + PTR_W'(w_ra);
    w_occ_nxt = w_wr_nxt - w_rd_nxt;

    w_status_nxt         = r_status;
    w_status_nxt.full    = (w_occ_nxt == DEPTH_V);
    w_status_nxt.empty   = (w_occ_nxt == '0);
    w_status_nxt.afull   = (w_occ_nxt >= AFULL_V);
    w_status_nxt.aempty  = (w_occ_nxt <= AEMPTY_V);
    // Set beats clear when both happen in one cycle.
    w_status_nxt.ovrflw  = w_ovf_set | (r_status.ovrflw  & ~bus.clr_err);
    w_status_nxt.undrflw = w_unf_set | (r_status.undrflw & ~bus.clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ    <= '0;
      r_status <= STATUS_RST;
    end else begin
      r_occ    <= w_occ_nxt;
      r_status <= w_status_nxt;
    end
  end

  fifo_ptr #(.W(PTR_W)) u_wr_ptr (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.flush),
    .inc     (w_wa),
    .bin_ptr (w_wr_ptr),
    .gry_ptr (w_wr_gry)
  );

  fifo_ptr #(.W(PTR_W)) u_rd_ptr (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.flush),
    .inc     (w_ra),
    .bin_ptr (w_rd_ptr),
    .gry_ptr (w_rd_gry)
  );

  assign bus.wr_addr    = w_wr_ptr[DEPTH_W-1:0];
  assign bus.rd_addr    = w_rd_ptr[DEPTH_W-1:0];
  assign bus.ram_wr     = w_wa;
  assign bus.ram_rd     = w_ra;
  assign bus.wr_ptr_gry = w_wr_gry;
  assign bus.rd_ptr_gry = w_rd_gry;
  assign bus.occ        = r_occ;
  assign bus.full       = r_status.full;
  assign bus.empty      = r_status.empty;
  assign bus.afull      = r_status.afull;
  assign bus.aempty     = r_status.aempty;
  assign bus.ovrflw     = r_status.ovrflw;
  assign bus.undrflw    = r_status.undrflw;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl: directed scenarios plus random traffic
// against a counting model of the FIFO.
module tb_fifo_ptr_ctrl;

  localparam int unsigned DW    = 4;
  localparam int          DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: total writes/reads accepted since last clear, plus sticky errors.
  int m_wr = 0;
  int m_rd = 0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  always #5 clk = ~clk;

  fifo_ptr_ctrl_if #(.DEPTH_W(DW)) bus ();

  fifo_ptr_ctrl #(
    .DEPTH_W    (DW),
    .AFULL_LVL  (14),
    .AEMPTY_LVL (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [28:0] exp_snap();
    logic [4:0] w, r, o;
    int occ;
    occ = m_wr - m_rd;
    w = 5'(m_wr % 32);
    r = 5'(m_rd % 32);
    o = 5'(occ);
    return {w ^ (w >> 1), r ^ (r >> 1), o, occ == DEPTH, occ == 0, occ >= 14,
            occ <= 2, m_ovf, m_unf, 4'(m_wr % DEPTH), 4'(m_rd % DEPTH)};
  endfunction

  function automatic logic [28:0] act_snap();
    return {bus.wr_ptr_gry, bus.rd_ptr_gry, bus.occ, bus.full, bus.empty, bus.afull,
            bus.aempty, bus.ovrflw, bus.undrflw, bus.wr_addr, bus.rd_addr};
  endfunction

  function automatic logic [1:0] exp_strobes();
    int occ;
    occ = m_wr - m_rd;
    return {bus.wr_en && occ < DEPTH && !bus.flush, bus.rd_en && occ > 0 && !bus.flush};
  endfunction

  task automatic set_in(input bit f, input bit w, input bit r, input bit c);
    bus.flush   = f;
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.clr_err = c;
    #1;
  endtask

  // Advance one clock and apply the FIFO rules to the model.
  task automatic tick();
    int occ;
    bit ovs, uns;
    occ = m_wr - m_rd;
    ovs = bus.wr_en && occ == DEPTH;
    uns = bus.rd_en && occ == 0;
    @(posedge clk);
    if (bus.flush) begin
      m_wr = 0;
      m_rd = 0;
    end else begin
      if (bus.wr_en && occ < DEPTH) m_wr++;
      if (bus.rd_en && occ > 0)     m_rd++;
    end
    m_ovf = bus.clr_err ? ovs : (m_ovf | ovs);
    m_unf = bus.clr_err ? uns : (m_unf | uns);
    #1;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0;
    tick();
    n_tests++;
    if (act_snap() !== exp_snap()) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", act_snap(), exp_snap());
    end
    n_tests++;
    if ({bus.wr_ptr_gry, bus.rd_ptr_gry, bus.empty, bus.aempty} !== 12'b0000000000_11) begin
      n_fail++;
      $display("FAIL reset_gray: wr_gry=%b rd_gry=%b empty=%b aempty=%b",
               bus.wr_ptr_gry, bus.rd_ptr_gry, bus.empty, bus.aempty);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 17; i++) begin
      set_in(0, 1, 0, 0);
      n_tests++;
      if ({bus.ram_wr, bus.ram_rd} !== exp_strobes()) begin
        n_fail++;
        $display("FAIL fill_strobe[%0d]: got %b expected %b", i, {bus.ram_wr, bus.ram_rd}, exp_strobes());
      end
      tick();
      n_tests++;
      if (act_snap() !== exp_snap()) begin
        n_fail++;
        $display("FAIL fill_state[%0d]: got %h expected %h", i, act_snap(), exp_snap());
      end
    end
    n_tests++;
    if ({bus.wr_ptr_gry, bus.occ, bus.full, bus.ovrflw} !== 12'b11000_10000_1_1) begin
      n_fail++;
      $display("FAIL overflow: wr_gry=%b occ=%0d full=%b ovrflw=%b",
               bus.wr_ptr_gry, bus.occ, bus.full, bus.ovrflw);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 17; i++) begin
      set_in(0, 0, 1, 0);
      n_tests++;
      if ({bus.ram_wr, bus.ram_rd} !== exp_strobes()) begin
        n_fail++;
        $display("FAIL drain_strobe[%0d]: got %b expected %b", i, {bus.ram_wr, bus.ram_rd}, exp_strobes());
      end
      tick();
      n_tests++;
      if (act_snap() !== exp_snap()) begin
        n_fail++;
        $display("FAIL drain_state[%0d]: got %h expected %h", i, act_snap(), exp_snap());
      end
    end
    n_tests++;
    if ({bus.empty, bus.undrflw, bus.ovrflw} !== 3'b111) begin
      n_fail++;
      $display("FAIL underflow: empty=%b undrflw=%b ovrflw=%b", bus.empty, bus.undrflw, bus.ovrflw);
    end
    set_in(0, 0, 0, 1);
    tick();
    n_tests++;
    if ({bus.ovrflw, bus.undrflw} !== 2'b00) begin
      n_fail++;
      $display("FAIL clr_err: ovrflw=%b undrflw=%b expected 00", bus.ovrflw, bus.undrflw);
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [4:0] pw, pr;
    bit wrapped;
    wrapped = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, 0, 0);
      tick();
    end
    pw = bus.wr_ptr_gry;
    pr = bus.rd_ptr_gry;
    for (int i = 0; i < 40; i++) begin
      set_in(0, 1, 1, 0);
      n_tests++;
      if ({bus.ram_wr, bus.ram_rd} !== 2'b11) begin
        n_fail++;
        $display("FAIL b2b_strobe[%0d]: got %b expected 11", i, {bus.ram_wr, bus.ram_rd});
      end
      tick();
      if (m_wr % 32 == 0) wrapped = 1'b1;
      n_tests++;
      if (act_snap() !== exp_snap() || bus.occ !== 5'd5) begin
        n_fail++;
        $display("FAIL b2b_state[%0d]: got %h expected %h", i, act_snap(), exp_snap());
      end
      n_tests++;
      if ($countones(pw ^ bus.wr_ptr_gry) != 1 || $countones(pr ^ bus.rd_ptr_gry) != 1) begin
        n_fail++;
        $display("FAIL gray_step[%0d]: wr %b->%b rd %b->%b", i, pw, bus.wr_ptr_gry, pr, bus.rd_ptr_gry);
      end
      pw = bus.wr_ptr_gry;
      pr = bus.rd_ptr_gry;
    end
    n_tests++;
    if (!wrapped) begin
      n_fail++;
      $display("FAIL b2b_wrap: write pointer never wrapped, m_wr=%0d", m_wr);
    end
  endtask

  task automatic test_simul_full_empty();
    while (m_wr - m_rd < DEPTH) begin
      set_in(0, 1, 0, 0);
      tick();
    end
    set_in(0, 1, 1, 0);
    n_tests++;
    if ({bus.ram_wr, bus.ram_rd} !== 2'b01) begin
      n_fail++;
      $display("FAIL full_simul_strobe: got %b expected 01", {bus.ram_wr, bus.ram_rd});
    end
    tick();
    n_tests++;
    if (bus.occ !== 5'd15 || act_snap() !== exp_snap()) begin
      n_fail++;
      $display("FAIL full_simul: occ=%0d expected 15, state %h expected %h", bus.occ, act_snap(), exp_snap());
    end
    while (m_wr - m_rd > 0) begin
      set_in(0, 0, 1, 0);
      tick();
    end
    set_in(0, 1, 1, 0);
    n_tests++;
    if ({bus.ram_wr, bus.ram_rd} !== 2'b10) begin
      n_fail++;
      $display("FAIL empty_simul_strobe: got %b expected 10", {bus.ram_wr, bus.ram_rd});
    end
    tick();
    n_tests++;
    if (bus.occ !== 5'd1 || act_snap() !== exp_snap()) begin
      n_fail++;
      $display("FAIL empty_simul: occ=%0d expected 1, state %h expected %h", bus.occ, act_snap(), exp_snap());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      n_tests++;
      if ({bus.ram_wr, bus.ram_rd} !== exp_strobes()) begin
        n_fail++;
        $display("FAIL rand_strobe[%0d]: got %b expected %b", i, {bus.ram_wr, bus.ram_rd}, exp_strobes());
      end
      tick();
      n_tests++;
      if (act_snap() !== exp_snap()) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: got %h expected %h", i, act_snap(), exp_snap());
      end
    end
  endtask

  task automatic test_flush_rst();
    set_in(1, 0, 0, 1);
    tick();
    for (int i = 0; i < 9; i++) begin
      set_in(0, 1, 0, 0);
      tick();
    end
    set_in(1, 1, 0, 0);
    n_tests++;
    if (bus.occ !== 5'd9 || bus.ram_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_strobe: occ=%0d ram_wr=%b expected occ 9 ram_wr 0", bus.occ, bus.ram_wr);
    end
    tick();
    n_tests++;
    if (act_snap() !== exp_snap() || bus.wr_ptr_gry !== 5'd0 || bus.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: got %h expected %h", act_snap(), exp_snap());
    end
    for (int i = 0; i < 6; i++) begin
      set_in(0, 1, i[0], 0);
      tick();
    end
    #2;
    rst = 1'b1;
    m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0;
    #1;
    n_tests++;
    if (act_snap() !== exp_snap()) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", act_snap(), exp_snap());
    end
    set_in(0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back_wrap();
    test_simul_full_empty();
    test_random();
    test_flush_rst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
